// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM stream reader.
package rom_stream_pkg;

    // Run controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Output buffer depth. This covers the one-cycle ROM latency, so one
    // word per cycle can flow while the consumer holds ready high.
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_fifo2.sv
// Two-entry synchronous FIFO holding captured ROM words for the output stream.
module rom_stream_fifo2
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  not_empty,
    output logic [1:0]            occupancy
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  do_push, do_pop;

    // Next-state logic. A push into a full FIFO is accepted only when a pop
    // frees a slot in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_pop   = pop && (occ_q != 2'd0);
        do_push  = push && ((occ_q != DEPTH) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign not_empty = (occ_q != 2'd0);
    assign occupancy = occ_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive ROM words and presents them on a valid/ready stream.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
    localparam logic [2:0]            DEPTH3   = 3'(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  issue;
    logic [1:0]            occ;
    logic [2:0]            pending;

    // Output buffer. A read issued last cycle lands here this cycle.
    rom_stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (rom_data),
        .pop       (pop),
        .head_data (m_data),
        .not_empty (m_valid),
        .occupancy (occ)
    );

    assign pop     = m_valid && m_ready;
    // Words already buffered or still in the ROM pipeline. A new read is
    // allowed only if it still fits after this cycle's pop.
    assign pending = {1'b0, occ} + {2'b00, inflight_q};
    assign issue   = (state_q == ST_RUN) && (remaining_q != '0)
                     && (pending < (DEPTH3 + {2'b00, pop}));

    assign rom_en   = issue;
    assign rom_addr = next_addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    // FSM next-state and counter updates.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d     = ST_RUN;
                        next_addr_d = start_addr;
                        remaining_d = count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    next_addr_d = next_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Finish once the last word leaves and nothing is still coming.
                if (!inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader paired with a rom_case style ROM model.
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  count;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    function automatic logic [15:0] rom_word(input logic [3:0] a);
        case (a)
            4'd0:    return 16'h200A;
            4'd1:    return 16'h0300;
            4'd2:    return 16'h8101;
            4'd3:    return 16'h4000;
            4'd14:   return 16'h0102;
            4'd15:   return 16'h4002;
            default: return 16'h0000;
        endcase
    endfunction

    // Registered ROM output, held while en is low.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept words with ready high until done; checks order and count.
    task automatic collect(input string tag, input int base, input int n);
        int  k    = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (m_valid && m_ready) begin
                check({tag, " data"}, 32'(m_data), 32'(rom_word(4'((base + k) % 16))));
                k++;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check({tag, " words"}, 32'(k), 32'(n));
        check({tag, " done seen"}, 32'(seen), 32'd1);
        cyc();
    endtask

    initial begin
        int  issued;
        int  idx;
        bit  stall_prev;
        bit  seen;
        logic [15:0] prev_data;

        rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; m_ready = 1'b0;
        cyc(); cyc();
        check("rst busy",   32'(busy),     32'd0);
        check("rst done",   32'(done),     32'd0);
        check("rst rom_en", 32'(rom_en),   32'd0);
        check("rst addr",   32'(rom_addr), 32'd0);
        check("rst valid",  32'(m_valid),  32'd0);
        check("rst data",   32'(m_data),   32'd0);
        rst_n = 1'b1;
        cyc();

        // Run of 4 from address 0, consumer always ready.
        start = 1'b1; start_addr = 4'd0; count = 5'd4; m_ready = 1'b1;
        #1;
        check("t1 en c0", 32'(rom_en), 32'd0);
        check("t1 busy c0", 32'(busy), 32'd0);
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            check("t1 rom_en", 32'(rom_en), 32'(c <= 4));
            if (c <= 4) check("t1 rom_addr", 32'(rom_addr), 32'(c - 1));
            check("t1 valid", 32'(m_valid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("t1 data", 32'(m_data), 32'(rom_word(4'(c - 3))));
            check("t1 done", 32'(done), 32'(c == 7));
            check("t1 busy", 32'(busy), 32'(c <= 6));
            cyc();
        end

        // Address wrap: 14, 15, 0.
        start = 1'b1; start_addr = 4'd14; count = 5'd3;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check("t2 rom_en", 32'(rom_en), 32'(c <= 3));
            if (c <= 3) check("t2 rom_addr", 32'(rom_addr), 32'((14 + c - 1) % 16));
            check("t2 valid", 32'(m_valid), 32'(c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) check("t2 data", 32'(m_data), 32'(rom_word(4'((14 + c - 3) % 16))));
            check("t2 done", 32'(done), 32'(c == 6));
            cyc();
        end

        // Zero-length run.
        start = 1'b1; start_addr = 4'd5; count = 5'd0;
        #1;
        check("t3 en c0", 32'(rom_en), 32'd0);
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            check("t3 rom_en", 32'(rom_en),  32'd0);
            check("t3 busy",   32'(busy),    32'd0);
            check("t3 valid",  32'(m_valid), 32'd0);
            check("t3 done",   32'(done),    32'(c == 1));
            cyc();
        end

        // Full-depth run with a random 50% consumer.
        start = 1'b1; start_addr = 4'd0; count = 5'd16; m_ready = 1'b0;
        cyc();
        start = 1'b0;
        issued = 0; idx = 0; stall_prev = 1'b0; seen = 1'b0; prev_data = '0;
        for (int i = 0; i < 400; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                check("t4 stall valid", 32'(m_valid), 32'd1);
                check("t4 stall data",  32'(m_data),  32'(prev_data));
            end
            if (rom_en) issued++;
            if (m_valid && m_ready) begin
                check("t4 data", 32'(m_data), 32'(rom_word(4'(idx % 16))));
                idx++;
            end
            check("t4 outstanding<=2", 32'(issued - idx <= 2), 32'd1);
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check("t4 done seen", 32'(seen),   32'd1);
        check("t4 words",     32'(idx),    32'd16);
        check("t4 issued",    32'(issued), 32'd16);
        cyc();

        // Consumer stalls for 10 cycles after first valid.
        start = 1'b1; start_addr = 4'd0; count = 5'd4; m_ready = 1'b0;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            check("t5 rom_en", 32'(rom_en), 32'(c <= 2));
            if (c >= 3) begin
                check("t5 hold valid", 32'(m_valid), 32'd1);
                check("t5 hold data",  32'(m_data),  32'h200A);
            end
            cyc();
        end
        m_ready = 1'b1;
        collect("t5", 0, 4);

        // Start while busy is ignored; reset mid-run clears everything.
        start = 1'b1; start_addr = 4'd0; count = 5'd4; m_ready = 1'b1;
        cyc();
        start = 1'b1; start_addr = 4'd8; count = 5'd2;
        #1;
        check("t6 busy c1", 32'(busy), 32'd1);
        cyc();
        start = 1'b0;
        #1;
        check("t6 addr c2", 32'(rom_addr), 32'd1);
        check("t6 en c2",   32'(rom_en),   32'd1);
        cyc();
        #1;
        check("t6 data c3", 32'(m_data), 32'h200A);
        cyc();
        #1;
        check("t6 data c4", 32'(m_data), 32'h0300);
        cyc();
        rst_n = 1'b0;
        cyc();
        check("t6 rst busy",   32'(busy),     32'd0);
        check("t6 rst done",   32'(done),     32'd0);
        check("t6 rst rom_en", 32'(rom_en),   32'd0);
        check("t6 rst addr",   32'(rom_addr), 32'd0);
        check("t6 rst valid",  32'(m_valid),  32'd0);
        check("t6 rst data",   32'(m_data),   32'd0);
        rst_n = 1'b1;
        cyc();
        check("t6 idle en",    32'(rom_en),   32'd0);
        check("t6 idle valid", 32'(m_valid),  32'd0);
        start = 1'b1; start_addr = 4'd3; count = 5'd1;
        cyc();
        start = 1'b0;
        collect("t6 rerun", 3, 1);
        check("t6 end busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
